// File: rtl/mips_pkg.sv
// Shared definitions for the MIPS program loader: FSM encoding, memory
// geometry defaults and stream framing constants.
package mips_pkg;

    localparam int MEM_DEPTH_DEF  = 1024;
    localparam int ADDR_W_DEF     = 10;

    // Stream framing: two length bytes, four bytes per word, one checksum byte
    localparam int HDR_BYTES      = 2;
    localparam int BYTES_PER_WORD = 4;
    localparam int CSUM_BYTES     = 1;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LEN_HI = 3'd1,
        ST_LEN_LO = 3'd2,
        ST_DATA   = 3'd3,
        ST_CSUM   = 3'd4,
        ST_DONE   = 3'd5,
        ST_ERR    = 3'd6
    } state_t;

endpackage

// File: rtl/mips_prog_loader_if.sv
// Byte-stream input and memory write port of the program loader.
interface mips_prog_loader_if #(
    parameter int ADDR_W = mips_pkg::ADDR_W_DEF
) ();
    logic              in_valid;
    logic              in_ready;
    logic [7:0]        in_data;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wdata;

    // master feeds bytes and observes the memory writes; slave is the loader
    modport master (
        output in_valid, in_data,
        input  in_ready, mem_we, mem_addr, mem_wdata
    );

    modport slave (
        input  in_valid, in_data,
        output in_ready, mem_we, mem_addr, mem_wdata
    );
endinterface

// File: rtl/mips_byte_packer.sv
// Packs four big-endian bytes into a 32-bit word and emits a one-cycle
// registered word strobe on the cycle after the fourth byte.
module mips_byte_packer
    import mips_pkg::*;
(
    input  logic        clk1,
    input  logic        rst,
    input  logic        clr,
    input  logic        byte_en,
    input  logic [7:0]  byte_in,
    output logic        word_valid,
    output logic [31:0] word
);

    logic [23:0] shift_reg;
    logic [1:0]  cnt_reg;
    logic        last_byte;

    assign last_byte = (cnt_reg == 2'(BYTES_PER_WORD - 1));

    always_ff @(posedge clk1 or posedge rst) begin
        if (rst) begin
            shift_reg  <= '0;
            cnt_reg    <= '0;
            word_valid <= 1'b0;
            word       <= '0;
        end else begin
            word_valid <= 1'b0;
            if (clr) begin
                shift_reg <= '0;
                cnt_reg   <= '0;
            end else if (byte_en) begin
                shift_reg <= {shift_reg[15:0], byte_in};
                cnt_reg   <= cnt_reg + 2'd1;
                // word holds its value until the next word completes
                if (last_byte) begin
                    word_valid <= 1'b1;
                    word       <= {shift_reg, byte_in};
                end
            end
        end
    end

endmodule

// File: rtl/mips_prog_loader.sv
// Boot loader: receives a length-prefixed, XOR-checksummed byte stream,
// writes it word by word into instruction memory, then releases the core.
module mips_prog_loader
    import mips_pkg::*;
#(
    parameter int MEM_DEPTH = MEM_DEPTH_DEF,
    parameter int ADDR_W    = ADDR_W_DEF
) (
    input  logic                clk1,
    input  logic                rst,
    input  logic                start,
    mips_prog_loader_if.slave   bus,
    output logic                busy,
    output logic                core_run,
    output logic                err
);

    localparam logic [16:0]       DEPTH_LIM = 17'(MEM_DEPTH);
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(MEM_DEPTH - 1);

    state_t            state_reg, state_next;
    logic [7:0]        len_hi_reg;
    logic [15:0]       len_reg;
    logic [17:0]       byte_cnt_reg;
    logic [7:0]        csum_reg;
    logic [ADDR_W-1:0] addr_reg;

    logic              accept;
    logic              start_ok;
    logic [15:0]       len_rx;
    logic              len_bad;
    logic [17:0]       last_payload;
    logic              packer_en;

    assign accept       = bus.in_valid && bus.in_ready;
    assign start_ok     = start && (state_reg == ST_IDLE || state_reg == ST_DONE ||
                                    state_reg == ST_ERR);
    assign len_rx       = {len_hi_reg, bus.in_data};
    assign len_bad      = (len_rx == 16'd0) || ({1'b0, len_rx} > DEPTH_LIM);
    assign last_payload = {len_reg, 2'b00} - 18'd1;
    assign packer_en    = accept && (state_reg == ST_DATA);

    always_ff @(posedge clk1 or posedge rst) begin
        if (rst) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE, ST_DONE, ST_ERR: if (start) state_next = ST_LEN_HI;
            ST_LEN_HI: if (accept) state_next = ST_LEN_LO;
            ST_LEN_LO: if (accept) state_next = len_bad ? ST_ERR : ST_DATA;
            ST_DATA:   if (accept && byte_cnt_reg == last_payload) state_next = ST_CSUM;
            ST_CSUM:   if (accept) state_next = (bus.in_data == csum_reg) ? ST_DONE : ST_ERR;
            default:   state_next = ST_IDLE;
        endcase
    end

    always_comb begin
        bus.in_ready = 1'b0;
        busy         = 1'b0;
        core_run     = 1'b0;
        err          = 1'b0;
        case (state_reg)
            ST_LEN_HI, ST_LEN_LO, ST_DATA, ST_CSUM: begin
                bus.in_ready = 1'b1;
                busy         = 1'b1;
            end
            ST_DONE: core_run = 1'b1;
            ST_ERR:  err      = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk1 or posedge rst) begin
        if (rst) begin
            len_hi_reg   <= '0;
            len_reg      <= '0;
            byte_cnt_reg <= '0;
            csum_reg     <= '0;
        end else if (start_ok) begin
            len_hi_reg   <= '0;
            len_reg      <= '0;
            byte_cnt_reg <= '0;
            csum_reg     <= '0;
        end else if (accept) begin
            case (state_reg)
                ST_LEN_HI: len_hi_reg <= bus.in_data;
                ST_LEN_LO: len_reg    <= len_rx;
                ST_DATA: begin
                    byte_cnt_reg <= byte_cnt_reg + 18'd1;
                    csum_reg     <= csum_reg ^ bus.in_data;
                end
                default: ;
            endcase
        end
    end

    // Address advances after each write strobe; it parks on the last word
    // rather than wrapping when a full-depth image is loaded.
    always_ff @(posedge clk1 or posedge rst) begin
        if (rst) begin
            addr_reg <= '0;
        end else if (start_ok) begin
            addr_reg <= '0;
        end else if (bus.mem_we && addr_reg != LAST_ADDR) begin
            addr_reg <= addr_reg + 1'b1;
        end
    end

    assign bus.mem_addr = addr_reg;

    mips_byte_packer u_packer (
        .clk1       (clk1),
        .rst        (rst),
        .clr        (start_ok),
        .byte_en    (packer_en),
        .byte_in    (bus.in_data),
        .word_valid (bus.mem_we),
        .word       (bus.mem_wdata)
    );

endmodule

// File: tb/tb_mips_prog_loader.sv
// Self-checking bench for mips_prog_loader: directed and randomized load
// sessions compared against a stream-level reference model.
module tb_mips_prog_loader;

    logic clk1 = 1'b0;
    logic rst;
    logic start;
    logic busy;
    logic core_run;
    logic err;

    int n_cmp       = 0;
    int n_mis       = 0;
    int writes_seen = 0;

    typedef struct packed {
        logic [9:0]  a;
        logic [31:0] d;
    } wr_t;

    wr_t         exp_q[$];
    wr_t         mon_e;
    logic [31:0] wbuf [0:1023];

    mips_prog_loader_if #(.ADDR_W(10)) bus ();

    mips_prog_loader #(
        .MEM_DEPTH (1024),
        .ADDR_W    (10)
    ) dut (
        .clk1     (clk1),
        .rst      (rst),
        .start    (start),
        .bus      (bus),
        .busy     (busy),
        .core_run (core_run),
        .err      (err)
    );

    always #5 clk1 = ~clk1;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_cmp++;
        if (obs !== exp_v) begin
            n_mis++;
            $display("FAIL %s: got 0x%08h, want 0x%08h", tag, obs, exp_v);
        end
    endtask

    // Write monitor: every strobe must match the head of the expected queue
    always @(negedge clk1) begin
        if (bus.mem_we === 1'b1) begin
            writes_seen++;
            if (exp_q.size() == 0) begin
                check_val("unexpected_we", 32'd1, 32'd0);
            end else begin
                mon_e = exp_q.pop_front();
                check_val("wr_addr", 32'(bus.mem_addr), 32'(mon_e.a));
                check_val("wr_data", bus.mem_wdata, mon_e.d);
            end
        end
    end

    task automatic send_byte(input logic [7:0] b, input int gap, input bit with_start);
        repeat (gap) begin
            bus.in_valid = 1'b0;
            @(negedge clk1);
        end
        bus.in_valid = 1'b1;
        bus.in_data  = b;
        start        = with_start;
        check_val("in_ready", 32'(bus.in_ready), 32'd1);
        @(negedge clk1);
        bus.in_valid = 1'b0;
        start        = 1'b0;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk1);
        start = 1'b0;
        check_val("start_busy", 32'(busy), 32'd1);
        check_val("start_err", 32'(err), 32'd0);
        check_val("start_run", 32'(core_run), 32'd0);
    endtask

    // Full session: model computes expected writes and result from the
    // stream rules, then the stream is driven with optional gaps.
    task automatic run_session(input string name, input int n_field, input bit bad_cs,
                               input int gap_max, input bit fixed_gap, input int start_at);
        logic [7:0]  cs;
        logic [7:0]  b;
        logic [15:0] nf;
        bit          legal;
        bit          exp_done;
        int          exp_w;
        int          gap;
        cs       = 8'h00;
        nf       = 16'(n_field);
        legal    = (n_field >= 1) && (n_field <= 1024);
        exp_done = legal && !bad_cs;
        exp_w    = legal ? n_field : 0;
        exp_q.delete();
        writes_seen = 0;
        if (legal) begin
            for (int i = 0; i < n_field; i++) begin
                exp_q.push_back({10'(i), wbuf[i]});
                cs = cs ^ wbuf[i][31:24] ^ wbuf[i][23:16] ^ wbuf[i][15:8] ^ wbuf[i][7:0];
            end
        end
        pulse_start();
        send_byte(nf[15:8], fixed_gap ? gap_max : $urandom_range(gap_max, 0), 1'b0);
        send_byte(nf[7:0],  fixed_gap ? gap_max : $urandom_range(gap_max, 0), 1'b0);
        if (!legal) begin
            check_val("err_after_len", 32'(err), 32'd1);
            check_val("rdy_after_len", 32'(bus.in_ready), 32'd0);
        end else begin
            for (int i = 0; i < n_field; i++) begin
                for (int k = 3; k >= 0; k--) begin
                    b   = wbuf[i][8*k +: 8];
                    gap = fixed_gap ? gap_max : int'($urandom_range(gap_max, 0));
                    send_byte(b, gap, (i*4 + (3-k)) == start_at);
                end
            end
            send_byte(cs ^ (bad_cs ? 8'h01 : 8'h00),
                      fixed_gap ? gap_max : $urandom_range(gap_max, 0), 1'b0);
        end
        repeat (3) @(negedge clk1);
        check_val("end_busy", 32'(busy), 32'd0);
        check_val("end_run", 32'(core_run), 32'(exp_done));
        check_val("end_err", 32'(err), 32'(!exp_done));
        check_val("end_ready", 32'(bus.in_ready), 32'd0);
        check_val("write_count", 32'(writes_seen), 32'(exp_w));
        check_val("exp_q_left", 32'(exp_q.size()), 32'd0);
        $display("session %s: N=%0d bad_cs=%0d writes=%0d run=%0d err=%0d",
                 name, n_field, bad_cs, writes_seen, core_run, err);
    endtask

    task automatic load_spec_words();
        wbuf[0] = 32'h20010005;
        wbuf[1] = 32'h00221800;
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst          = 1'b1;
        start        = 1'b0;
        bus.in_valid = 1'b0;
        bus.in_data  = 8'h00;
        repeat (3) @(negedge clk1);
        check_val("rst_busy", 32'(busy), 32'd0);
        check_val("rst_run", 32'(core_run), 32'd0);
        check_val("rst_err", 32'(err), 32'd0);
        check_val("rst_ready", 32'(bus.in_ready), 32'd0);
        check_val("rst_we", 32'(bus.mem_we), 32'd0);
        check_val("rst_addr", 32'(bus.mem_addr), 32'd0);
        check_val("rst_wdata", bus.mem_wdata, 32'd0);
        rst = 1'b0;
        @(negedge clk1);
        $display("reset: outputs checked");

        load_spec_words();
        run_session("normal", 2, 1'b0, 0, 1'b1, -1);
        run_session("bad_cs", 2, 1'b1, 0, 1'b1, -1);
        run_session("len_zero", 0, 1'b0, 0, 1'b1, -1);
        run_session("len_0401", 16'h0401, 1'b0, 0, 1'b1, -1);
        run_session("gaps3", 2, 1'b0, 3, 1'b1, -1);

        // Abort after six payload bytes: only word 0 may reach memory
        exp_q.delete();
        exp_q.push_back({10'd0, wbuf[0]});
        writes_seen = 0;
        pulse_start();
        send_byte(8'h00, 0, 1'b0);
        send_byte(8'h02, 0, 1'b0);
        for (int j = 0; j < 6; j++) begin
            send_byte(wbuf[j/4][8*(3 - j%4) +: 8], 0, 1'b0);
        end
        rst = 1'b1;
        #1;
        check_val("abort_busy", 32'(busy), 32'd0);
        check_val("abort_run", 32'(core_run), 32'd0);
        check_val("abort_err", 32'(err), 32'd0);
        check_val("abort_ready", 32'(bus.in_ready), 32'd0);
        check_val("abort_we", 32'(bus.mem_we), 32'd0);
        check_val("abort_addr", 32'(bus.mem_addr), 32'd0);
        check_val("abort_wdata", bus.mem_wdata, 32'd0);
        @(negedge clk1);
        rst = 1'b0;
        repeat (10) @(negedge clk1);
        check_val("abort_writes", 32'(writes_seen), 32'd1);
        check_val("abort_q_left", 32'(exp_q.size()), 32'd0);
        $display("session abort: writes=%0d", writes_seen);
        run_session("after_abort", 2, 1'b0, 0, 1'b1, -1);

        for (int s = 0; s < 6; s++) begin
            int n;
            n = int'($urandom_range(8, 1));
            for (int i = 0; i < n; i++) wbuf[i] = $urandom;
            run_session("random", n, bit'($urandom_range(1, 0)), 2, 1'b0, -1);
        end

        for (int i = 0; i < 1024; i++) wbuf[i] = 32'(i);
        run_session("full_depth", 1024, 1'b0, 0, 1'b1, 2000);
        check_val("last_addr", 32'(bus.mem_addr), 32'd1023);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule

// File: doc/mips_prog_loader.md
MIPS_PROG_LOADER -- requirements
Module: mips_prog_loader

Interface
REQ-001 SHALL have parameter MEM_DEPTH, default 1024, meaning instruction/data memory depth in 32-bit words.
REQ-002 SHALL have parameter ADDR_W, default 10, meaning memory word-address width (clog2 of MEM_DEPTH).
REQ-003 SHALL have port clk1, input, 1, the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst, input, 1, asynchronous active-high reset.
REQ-005 SHALL have port start, input, 1, a one-cycle pulse that begins a load session.
REQ-006 SHALL have port in_valid, input, 1, byte-stream valid.
REQ-007 SHALL have port in_data, input, 8, byte-stream data.
REQ-008 SHALL have port in_ready, output, 1, byte-stream ready; a byte transfers when in_valid and in_ready are both high.
REQ-009 SHALL have port mem_we, output, 1, one-cycle memory word write strobe.
REQ-010 SHALL have port mem_addr, output, ADDR_W, memory word address.
REQ-011 SHALL have port mem_wdata, output, 32, memory write data.
REQ-012 SHALL have port busy, output, 1, high while a session is in progress.
REQ-013 SHALL have port core_run, output, 1, high when the core may fetch and execute.
REQ-014 SHALL have port err, output, 1, sticky error flag.

Function
REQ-015 SHALL accept the stream format: LEN_HI, LEN_LO (16-bit word count N, big-endian), then 4*N payload bytes (each word big-endian, MSB first), then one checksum byte.
REQ-016 SHALL implement the FSM IDLE -> LEN_HI -> LEN_LO -> DATA -> CSUM -> DONE, and SHALL enter ERR from LEN_LO or CSUM.
REQ-017 SHALL hold in_ready low in IDLE, DONE and ERR, and high in LEN_HI, LEN_LO, DATA and CSUM.
REQ-018 SHALL move from IDLE, DONE or ERR to LEN_HI on start, clearing err, the checksum accumulator, the byte counter and the word address; start while busy SHALL be ignored.
REQ-019 SHALL go to ERR from LEN_LO when N == 0 or N > MEM_DEPTH.
REQ-020 SHALL pack 4 accepted DATA bytes into a word and, on the cycle after the 4th byte is accepted, assert mem_we for exactly one cycle with registered mem_addr/mem_wdata stable for that cycle.
REQ-021 SHALL start the write address at 0, increment it by 1 per written word, and never wrap within a session (bounded by REQ-019).
REQ-022 SHALL go to CSUM after the 4*N-th payload byte is accepted.
REQ-023 SHALL compute the checksum as the 8-bit XOR of all payload bytes (length bytes excluded); equal to the received checksum -> DONE, otherwise ERR.
REQ-024 SHALL assert busy in LEN_HI, LEN_LO, DATA and CSUM.
REQ-025 SHALL assert core_run only in DONE, holding it until start or rst; err SHALL be high only in ERR.
REQ-026 SHALL ignore in_valid gaps: cycles with in_valid low advance no state.
REQ-027 SHALL accept a byte every cycle (throughput 1 byte/clk) and SHALL NOT exert backpressure from the memory side.

Reset
REQ-028 SHALL, on rst, immediately force state IDLE, and in_ready, mem_we, busy, core_run and err to 0, with mem_addr, mem_wdata, counters and checksum at 0.
REQ-029 SHALL, on rst asserted mid-session, abort the session; words already written remain in memory and no further mem_we is issued.

Structure
REQ-030 SHALL place the FSM state encoding, MEM_DEPTH/ADDR_W defaults and the header/checksum byte-count constants in the shared package mips_pkg.
REQ-031 SHALL implement byte-to-word assembly (shift register plus 2-bit byte counter) as sub-module mips_byte_packer; the FSM, checksum and address counter stay in the top level.

Verification
REQ-032 SHALL verify a normal load: start; stream 00 02 | 20 01 00 05 | 00 22 18 00 | cs=0x1E -> mem_we at addr 0 with 0x20010005, at addr 1 with 0x00221800, then DONE, core_run=1, err=0.
REQ-033 SHALL verify a bad checksum: same stream with cs=0x1F -> both words written, then ERR, err=1, core_run=0, in_ready=0.
REQ-034 SHALL verify illegal lengths: N=0x0000, and separately N=0x0401 -> ERR immediately after LEN_LO, no mem_we.
REQ-035 SHALL verify in_valid gaps: 3 idle cycles between every byte of REQ-032 -> identical writes and result; checksum byte on the last cycle ok.
REQ-036 SHALL verify reset mid-session: rst asserted after 6 payload bytes of N=2 -> word 0 written, no further mem_we, state IDLE, all outputs 0; a subsequent start plus full stream -> normal DONE.
REQ-037 SHALL verify a boundary load: N=1024 of incrementing words with correct checksum -> last write at addr 1023, DONE; start asserted during DATA is ignored.
